// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - round-robin issue select from the RS with multiplier occupancy tracking
module rs_issue_sched #(
    parameter int RS_SZ    = 5,
    parameter int IDX_W    = $clog2(RS_SZ),
    parameter int MULT_LAT = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [RS_SZ-1:0]   req_ready,
    input  logic [2*RS_SZ-1:0] req_fu,
    input  logic               is_stall,
    input  logic               flush,
    output logic               issue_valid,
    output logic [IDX_W-1:0]   issue_idx,
    output logic [1:0]         issue_fu,
    output logic [RS_SZ-1:0]   issue_grant,
    output logic               mult_busy
);

    localparam int         CNT_W   = $clog2(MULT_LAT);
    localparam logic [1:0] FU_MULT = 2'd3;

    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] mult_cnt;
    logic             accept;
    logic             accept_mult;
    logic             mult_free;
    logic [RS_SZ-1:0] elig;
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [1:0]       win_fu;

    assign accept      = issue_valid && !is_stall;
    assign accept_mult = accept && (issue_fu == FU_MULT);
    // A new MULT may be selected on the edge where the counter drains to zero,
    // so its accept lands exactly MULT_LAT cycles after the previous one.
    assign mult_free   = (mult_cnt <= CNT_W'(1)) && !accept_mult;

    always_comb begin
        elig = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            elig[i] = req_ready[i]
                   && !(accept && (int'(issue_idx) == i))
                   && ((req_fu[2*i +: 2] != FU_MULT) || mult_free);
        end
    end

    always_comb begin
        int j;
        found   = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int k = 0; k < RS_SZ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= RS_SZ) begin
                j = j - RS_SZ;
            end
            if (!found && elig[j]) begin
                found   = 1'b1;
                win_idx = IDX_W'(j);
            end
        end
    end

    assign win_fu = req_fu[2*int'(win_idx) +: 2];

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_valid <= 1'b0;
            issue_idx   <= '0;
            issue_fu    <= '0;
            rr_ptr      <= '0;
            mult_cnt    <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
            mult_cnt    <= '0;
        end else begin
            if (accept_mult) begin
                mult_cnt <= CNT_W'(MULT_LAT - 1);
            end else if (mult_cnt != '0) begin
                mult_cnt <= mult_cnt - CNT_W'(1);
            end

            if (!issue_valid || accept) begin
                if (found) begin
                    issue_valid <= 1'b1;
                    issue_idx   <= win_idx;
                    issue_fu    <= win_fu;
                    rr_ptr      <= (win_idx == IDX_W'(RS_SZ - 1)) ? '0 : win_idx + IDX_W'(1);
                end else begin
                    issue_valid <= 1'b0;
                end
            end
        end
    end

    assign issue_grant = (accept && !flush) ? (RS_SZ'(1) << issue_idx) : '0;
    assign mult_busy   = (mult_cnt != '0);

endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - directed vector bench for rs_issue_sched
module tb_rs_issue_sched;

    localparam int RS_SZ = 5;
    localparam int IDX_W = 3;
    localparam logic [9:0] F0 = 10'h000;
    localparam logic [9:0] FM = 10'h3C0;

    logic             clock;
    logic             reset;
    logic [4:0]       req_ready;
    logic [9:0]       req_fu;
    logic             is_stall;
    logic             flush;
    logic             issue_valid;
    logic [IDX_W-1:0] issue_idx;
    logic [1:0]       issue_fu;
    logic [4:0]       issue_grant;
    logic             mult_busy;

    typedef struct {
        logic       rst;
        logic [4:0] rdy;
        logic [9:0] fu;
        logic       stall;
        logic       fl;
        logic       chk;
        logic       e_valid;
        logic [2:0] e_idx;
        logic [1:0] e_fu;
        logic [4:0] e_grant;
        logic       e_busy;
    } vec_t;

    vec_t vq[$];
    int   n_checks;
    int   n_pass;

    rs_issue_sched #(.RS_SZ(RS_SZ), .IDX_W(IDX_W), .MULT_LAT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_ready   (req_ready),
        .req_fu      (req_fu),
        .is_stall    (is_stall),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issue_fu    (issue_fu),
        .issue_grant (issue_grant),
        .mult_busy   (mult_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic [4:0] rdy, input logic [9:0] fu,
                                input logic stall, input logic fl, input logic chk,
                                input logic ev, input logic [2:0] ei, input logic [1:0] ef,
                                input logic [4:0] eg, input logic eb);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.fu = fu; v.stall = stall; v.fl = fl; v.chk = chk;
        v.e_valid = ev; v.e_idx = ei; v.e_fu = ef; v.e_grant = eg; v.e_busy = eb;
        return v;
    endfunction

    // Drive inputs, let combinational grant settle, compare, then advance one edge.
    task automatic step(input vec_t v, input int row);
        reset     = v.rst;
        req_ready = v.rdy;
        req_fu    = v.fu;
        is_stall  = v.stall;
        flush     = v.fl;
        #1;
        if (v.chk) begin
            n_checks++;
            if ({issue_valid, issue_idx, issue_fu, issue_grant, mult_busy} ==
                {v.e_valid, v.e_idx, v.e_fu, v.e_grant, v.e_busy}) begin
                n_pass++;
            end else begin
                $display("FAIL row%0d: got v=%0b idx=%0d fu=%0d grant=%05b busy=%0b, want v=%0b idx=%0d fu=%0d grant=%05b busy=%0b",
                         row, issue_valid, issue_idx, issue_fu, issue_grant, mult_busy,
                         v.e_valid, v.e_idx, v.e_fu, v.e_grant, v.e_busy);
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        req_ready = '0;
        req_fu    = '0;
        is_stall  = 1'b0;
        flush     = 1'b0;

        // Two pending ALU entries drain in order, then rr_ptr=3 shown by the next pick.
        vq.push_back(mk(1, 5'b00000, F0, 0, 0, 0, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(1, 5'b00000, F0, 0, 0, 0, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00101, F0, 0, 0, 1, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00101, F0, 0, 0, 1, 1, 0, 0, 5'b00001, 0));
        vq.push_back(mk(0, 5'b00100, F0, 0, 0, 1, 1, 2, 0, 5'b00100, 0));
        vq.push_back(mk(0, 5'b00000, F0, 0, 0, 1, 0, 2, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b11111, F0, 0, 0, 1, 0, 2, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b11111, F0, 0, 0, 1, 1, 3, 0, 5'b01000, 0));
        vq.push_back(mk(0, 5'b00000, F0, 0, 0, 1, 1, 4, 0, 5'b10000, 0));
        vq.push_back(mk(0, 5'b00000, F0, 0, 0, 1, 0, 4, 0, 5'b00000, 0));
        // All ready and held: strict rotation with wrap.
        vq.push_back(mk(1, 5'b00000, F0, 0, 0, 0, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b11111, F0, 0, 0, 1, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b11111, F0, 0, 0, 1, 1, 0, 0, 5'b00001, 0));
        vq.push_back(mk(0, 5'b11111, F0, 0, 0, 1, 1, 1, 0, 5'b00010, 0));
        vq.push_back(mk(0, 5'b11111, F0, 0, 0, 1, 1, 2, 0, 5'b00100, 0));
        vq.push_back(mk(0, 5'b11111, F0, 0, 0, 1, 1, 3, 0, 5'b01000, 0));
        vq.push_back(mk(0, 5'b11111, F0, 0, 0, 1, 1, 4, 0, 5'b10000, 0));
        vq.push_back(mk(0, 5'b11111, F0, 0, 0, 1, 1, 0, 0, 5'b00001, 0));
        // Stall holds entry 1 for three cycles.
        vq.push_back(mk(1, 5'b00000, F0, 0, 0, 0, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00010, F0, 0, 0, 1, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00010, F0, 1, 0, 1, 1, 1, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00010, F0, 1, 0, 1, 1, 1, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00010, F0, 1, 0, 1, 1, 1, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00010, F0, 0, 0, 1, 1, 1, 0, 5'b00010, 0));
        vq.push_back(mk(0, 5'b00000, F0, 0, 0, 1, 0, 1, 0, 5'b00000, 0));
        // Two MULTs spaced four cycles, ALU entry 0 fills the gap.
        vq.push_back(mk(1, 5'b00000, FM, 0, 0, 0, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b11000, FM, 0, 0, 1, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b11001, FM, 0, 0, 1, 1, 3, 3, 5'b01000, 0));
        vq.push_back(mk(0, 5'b10001, FM, 0, 0, 1, 1, 0, 0, 5'b00001, 1));
        vq.push_back(mk(0, 5'b10000, FM, 0, 0, 1, 0, 0, 0, 5'b00000, 1));
        vq.push_back(mk(0, 5'b10000, FM, 0, 0, 1, 0, 0, 0, 5'b00000, 1));
        vq.push_back(mk(0, 5'b10000, FM, 0, 0, 1, 1, 4, 3, 5'b10000, 0));
        vq.push_back(mk(0, 5'b00000, FM, 0, 0, 1, 0, 4, 3, 5'b00000, 1));
        // Flush after a MULT accept clears occupancy; entry 4 issues right after.
        vq.push_back(mk(1, 5'b00000, FM, 0, 0, 0, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b11000, FM, 0, 0, 1, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b11000, FM, 0, 0, 1, 1, 3, 3, 5'b01000, 0));
        vq.push_back(mk(0, 5'b10000, FM, 0, 1, 1, 0, 3, 3, 5'b00000, 1));
        vq.push_back(mk(0, 5'b10000, FM, 0, 0, 1, 0, 3, 3, 5'b00000, 0));
        vq.push_back(mk(0, 5'b10000, FM, 0, 0, 1, 1, 4, 3, 5'b10000, 0));
        vq.push_back(mk(0, 5'b00000, FM, 0, 0, 1, 0, 4, 3, 5'b00000, 1));
        // Flush beats stall, flush masks grant, rr_ptr held across flush.
        vq.push_back(mk(1, 5'b00000, F0, 0, 0, 0, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00100, F0, 0, 0, 1, 0, 0, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00100, F0, 1, 0, 1, 1, 2, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00100, F0, 1, 1, 1, 1, 2, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00100, F0, 0, 0, 1, 0, 2, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00100, F0, 0, 1, 1, 1, 2, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00100, F0, 0, 0, 1, 0, 2, 0, 5'b00000, 0));
        vq.push_back(mk(0, 5'b00100, F0, 0, 0, 1, 1, 2, 0, 5'b00100, 0));
        vq.push_back(mk(0, 5'b00000, F0, 0, 0, 1, 0, 2, 0, 5'b00000, 0));

        for (int r = 0; r < vq.size(); r++) begin
            step(vq[r], r);
        end

        // Reset while a stalled selection is held: everything back to reset values, rr_ptr=0.
        step(mk(1, 5'b00000, F0, 0, 0, 0, 0, 0, 0, 5'b00000, 0), 100);
        step(mk(0, 5'b00100, F0, 0, 0, 1, 0, 0, 0, 5'b00000, 0), 101);
        step(mk(0, 5'b00100, F0, 1, 0, 1, 1, 2, 0, 5'b00000, 0), 102);
        step(mk(1, 5'b00100, F0, 1, 0, 1, 1, 2, 0, 5'b00000, 0), 103);
        step(mk(0, 5'b11111, F0, 0, 0, 1, 0, 0, 0, 5'b00000, 0), 104);
        step(mk(0, 5'b11111, F0, 0, 0, 1, 1, 0, 0, 5'b00001, 0), 105);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
